ram_load_ctrl: RTL

- Sequences and shares the 16-byte program/data RAM between the CPU bus and an external program loader.
- In normal operation the CPU's RAM-in/RAM-out controls pass straight through.
- On a load request the controller stalls the CPU, accepts a byte stream on a valid/ready handshake, and writes it to consecutive addresses from 0. It then returns the RAM to the CPU.
- Sits between the control unit/MAR and the RAM module.

---
 rtl/ram_ctrl_pkg.sv | 14 +
 rtl/ram_load_ctrl_if.sv | 40 ++++
 rtl/ram_load_ptr.sv | 34 +++
 rtl/ram_load_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared constants and FSM state encoding for the program RAM loader and the RAM module.
// Optional feature macro used across this slice: LOAD_CHECKSUM_EN (adds ld_sum).
package ram_ctrl_pkg;

  localparam int RAM_INPUT_ADDR_DEF = 4;
  localparam int RAM_SIZE_DEF       = 16;

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_load_ctrl_if.sv
// Loader-side handshake bundle for ram_load_ctrl; the loader is master, the controller is slave.
// LOAD_CHECKSUM_EN adds the ld_sum return signal.
interface ram_load_ctrl_if #(
  parameter int AW = 4
);

  logic          ld_start;
  logic          ld_abort;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic [AW:0]   ld_count;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]    ld_sum;

  modport master (
    output ld_start, ld_abort, ld_valid, ld_data, ld_last,
    input  ld_ready, ld_busy, ld_done, ld_count, ld_sum
  );

  modport slave (
    input  ld_start, ld_abort, ld_valid, ld_data, ld_last,
    output ld_ready, ld_busy, ld_done, ld_count, ld_sum
  );
`else
  modport master (
    output ld_start, ld_abort, ld_valid, ld_data, ld_last,
    input  ld_ready, ld_busy, ld_done, ld_count
  );

  modport slave (
    input  ld_start, ld_abort, ld_valid, ld_data, ld_last,
    output ld_ready, ld_busy, ld_done, ld_count
  );
`endif

endinterface

// File: rtl/ram_load_ptr.sv
// Write pointer and byte counter for a RAM load: clear, increment, full flag.
// The pointer saturates at the last address; the counter can reach SIZE.
module ram_load_ptr #(
  parameter int AW   = 4,
  parameter int SIZE = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr,
  output logic [AW:0]   count,
  output logic          full
);

  assign full = (ptr == AW'(SIZE - 1));

  // NOTE: reset is synchronous here -- rst_n is only looked at inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (clr) begin
      ptr   <= '0;
      count <= '0;
    end else if (inc) begin
      count <= count + {{AW{1'b0}}, 1'b1};
      if (!full) begin
        ptr <= ptr + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/ram_load_ctrl.sv
// Shares the program RAM between the CPU and an external byte-stream loader.
// Define LOAD_CHECKSUM_EN to get a modulo-256 sum of the loaded bytes on ld.ld_sum.
import ram_ctrl_pkg::*;

module ram_load_ctrl #(
  parameter int RAM_INPUT_ADDR = RAM_INPUT_ADDR_DEF,
  parameter int RAM_SIZE       = RAM_SIZE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RAM_INPUT_ADDR-1:0] cpu_addr,
  input  logic [7:0]                cpu_data,
  input  logic                      cpu_ram_in,
  input  logic                      cpu_ram_out,
  output logic                      cpu_stall,
  ram_load_ctrl_if.slave            ld,
  output logic [RAM_INPUT_ADDR-1:0] ram_addr,
  output logic [7:0]                ram_data,
  output logic                      ram_in,
  output logic                      ram_out
);

  state_e                    state_q, state_d;
  logic [RAM_INPUT_ADDR-1:0] ptr;
  logic                      full;
  logic                      start_accept;
  logic                      handshake;

  // Starts are only honoured from CPU; abort suppresses a concurrent byte.
  assign start_accept = (state_q == ST_CPU) && ld.ld_start;
  assign handshake    = (state_q == ST_LOAD) && ld.ld_valid && !ld.ld_abort;

  ram_load_ptr #(
    .AW   (RAM_INPUT_ADDR),
    .SIZE (RAM_SIZE)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_accept),
    .inc   (handshake),
    .ptr   (ptr),
    .count (ld.ld_count),
    .full  (full)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    ram_addr    = ptr;
    ram_data    = ld.ld_data;
    ram_in      = 1'b0;
    ram_out     = 1'b0;
    cpu_stall   = 1'b1;
    ld.ld_ready = 1'b0;
    ld.ld_busy  = 1'b0;
    ld.ld_done  = 1'b0;
    case (state_q)
      ST_CPU: begin
        ram_addr  = cpu_addr;
        ram_data  = cpu_data;
        ram_in    = cpu_ram_in;
        ram_out   = cpu_ram_out & ~cpu_ram_in;
        cpu_stall = 1'b0;
        if (ld.ld_start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld.ld_busy  = 1'b1;
        ld.ld_ready = 1'b1;
        ram_in      = ld.ld_valid & ~ld.ld_abort;
        if (ld.ld_abort) begin
          state_d = ST_CPU;
        end else if (ld.ld_valid && (ld.ld_last || full)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ld.ld_busy = 1'b1;
        ld.ld_done = 1'b1;
        state_d    = ST_CPU;
      end
      default: begin
        state_d = ST_CPU;
      end
    endcase
  end

`ifdef LOAD_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (start_accept) begin
      sum_q <= '0;
    end else if (handshake) begin
      sum_q <= sum_q + ld.ld_data;
    end
  end

  assign ld.ld_sum = sum_q;
`endif

endmodule
